// File: rtl/descrambler.sv
`default_nettype none
// ============================================================================
//  Module   : descrambler
//  Purpose  : Serial x^7+x^4+1 frame descrambler. The first seven received
//             bits seed the LFSR, the rest of SERVICE is checked for zeros,
//             and the following Length bits are emitted as descrambled data.
//  Revision : 1.0 - initial release
// ============================================================================
module descrambler #(
    parameter int LEN_WIDTH    = 16,
    parameter int SERVICE_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [LEN_WIDTH-1:0] i_length,
    input  logic                 i_input,
    input  logic                 i_input_valid,
    output logic                 o_output,
    output logic                 o_output_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_service_err
);

    localparam int                   c_SEED_BITS = 7;
    localparam int                   c_SVC_W     = $clog2(SERVICE_BITS + 1);
    localparam logic [c_SVC_W-1:0]   c_SEED_LAST = c_SVC_W'(c_SEED_BITS - 1);
    localparam logic [c_SVC_W-1:0]   c_SVC_LAST  = c_SVC_W'(SERVICE_BITS - 1);
    localparam logic [c_SVC_W-1:0]   c_SVC_ONE   = c_SVC_W'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE   = LEN_WIDTH'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SEED    = 2'd1;
    localparam logic [1:0] c_SERVICE = 2'd2;
    localparam logic [1:0] c_DATA    = 2'd3;

    logic [1:0]           r_state,     w_state_nxt;
    logic [6:0]           r_sreg,      w_sreg_nxt;
    logic [c_SVC_W-1:0]   r_svc_cnt,   w_svc_cnt_nxt;
    logic [LEN_WIDTH-1:0] r_cnt,       w_cnt_nxt;
    logic [LEN_WIDTH-1:0] r_len,       w_len_nxt;
    logic                 r_out,       w_out_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 r_done,      w_done_nxt;
    logic                 r_svc_err,   w_svc_err_nxt;

    logic                 w_key;
    logic                 w_desc;
    logic                 w_last_data;

    assign w_key       = r_sreg[6] ^ r_sreg[3];
    assign w_desc      = i_input ^ w_key;
    // Counting from zero and comparing against Length-1 keeps the counter
    // below Length, so the full-scale Length never wraps it.
    assign w_last_data = (r_cnt == (r_len - c_LEN_ONE));

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_svc_cnt_nxt   = r_svc_cnt;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_svc_err_nxt   = r_svc_err;

        if (i_start) begin
            w_state_nxt   = c_SEED;
            w_len_nxt     = i_length;
            w_cnt_nxt     = '0;
            w_svc_cnt_nxt = '0;
            w_svc_err_nxt = 1'b0;
        end else if (i_input_valid) begin
            case (r_state)
                c_SEED: begin
                    w_sreg_nxt    = {r_sreg[5:0], i_input};
                    w_svc_cnt_nxt = r_svc_cnt + c_SVC_ONE;
                    if (r_svc_cnt == c_SEED_LAST) begin
                        w_state_nxt = c_SERVICE;
                    end
                end
                c_SERVICE: begin
                    w_sreg_nxt    = {r_sreg[5:0], w_key};
                    w_svc_cnt_nxt = r_svc_cnt + c_SVC_ONE;
                    if (w_desc) begin
                        w_svc_err_nxt = 1'b1;
                    end
                    if (r_svc_cnt == c_SVC_LAST) begin
                        if (r_len != '0) begin
                            w_state_nxt = c_DATA;
                        end else begin
                            w_state_nxt = c_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                c_DATA: begin
                    w_sreg_nxt      = {r_sreg[5:0], w_key};
                    w_out_nxt       = w_desc;
                    w_out_valid_nxt = 1'b1;
                    if (w_last_data) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_LEN_ONE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_sreg      <= '0;
            r_svc_cnt   <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_svc_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_svc_cnt   <= w_svc_cnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_svc_err   <= w_svc_err_nxt;
        end
    end

    assign o_output       = r_out;
    assign o_output_valid = r_out_valid;
    assign o_busy         = (r_state != c_IDLE);
    assign o_done         = r_done;
    assign o_service_err  = r_svc_err;

endmodule
`default_nettype wire

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Parameters
REQ-001 LEN_WIDTH, 16, width of the Length input and of the internal data-bit counter.
REQ-002 SERVICE_BITS, 16, SERVICE-field bits consumed before data output begins; the first 7 of these are seed bits.

Interface
REQ-003 Clock  input  1  single clock; all logic rising-edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle pulse that begins a frame and latches Length.
REQ-006 Length  input  LEN_WIDTH  number of data bits following SERVICE; sampled only on Start.
REQ-007 Input  input  1  serial bit from the ViterbiDecoder output.
REQ-008 InputValid  input  1  Input is consumed on every cycle in which this is high.
REQ-009 Output  output  1  descrambled data bit (registered).
REQ-010 OutputValid  output  1  Output qualifier, one cycle per data bit.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse after the last data bit, or after SERVICE when Length=0.
REQ-013 ServiceErr  output  1  sticky per frame; high if any descrambled SERVICE bit 7..15 is 1.

Function
REQ-014 The FSM shall have exactly four states: IDLE, SEED, SERVICE, DATA.
REQ-015 IDLE shall ignore Input/InputValid; Start shall latch Length, clear the counter and ServiceErr, and go to SEED.
REQ-016 Start in SEED, SERVICE or DATA shall abort the current frame, emit no Done, and restart as in REQ-015 in the same cycle.
REQ-017 Shift register S[6:0] (S[0] newest) shall be updated only on cycles with InputValid=1; when InputValid=0, state, S and the counter shall all hold.
REQ-018 SEED: each valid Input shall be shifted into S unchanged; after 7 valid bits the FSM shall go to SERVICE.
REQ-019 SERVICE/DATA: keystream k = S[6] XOR S[3] (x^7+x^4+1); each valid bit shall shift k into S and produce descrambled d = Input XOR k.
REQ-020 SERVICE: for SERVICE_BITS-7 valid bits, a 1 on d shall set ServiceErr; no OutputValid. After the last of these bits, go to DATA if Length>0; otherwise go to IDLE and pulse Done.
REQ-021 DATA: each valid bit shall drive Output=d and OutputValid=1 on the next cycle (latency 1 cycle from the InputValid edge).
REQ-022 The counter shall count data bits; on the Length-th bit, the FSM shall return to IDLE and pulse Done in the same cycle as the final OutputValid.
REQ-023 OutputValid shall be 0 in every cycle without a consumed DATA bit; Output shall hold its last value when invalid.
REQ-024 Length = 2^LEN_WIDTH-1 shall be supported without counter wrap.
REQ-025 ServiceErr shall hold from the end of SERVICE until the next Start or Reset.
REQ-026 Back-to-back frames: a Start in the same cycle as Done shall be accepted, and Done shall still be asserted.

Reset
REQ-027 Reset shall take priority over Start and InputValid.
REQ-028 On Reset, the FSM shall go to IDLE and S, the counter and latched Length shall be 0; Output, OutputValid, Busy, Done and ServiceErr shall all be 0 on the next cycle.
REQ-029 Reset asserted mid-frame shall discard the frame with no Done and no further OutputValid.

Verification
REQ-030 All-zero frame: Start with Length=8, feed the 24-bit scrambler sequence from the all-ones seed, 000011101111001011001001 -> Output 00000000, 8 OutputValid pulses, Done with the 8th, ServiceErr=0.
REQ-031 Round trip: scramble a random 100-bit payload using seed 1011101 and 16 zero SERVICE bits; InputValid toggles randomly -> payload recovered bit-exact, with exactly 100 OutputValid pulses.
REQ-032 SERVICE error: same stimulus as REQ-030 with input bit 10 inverted -> ServiceErr=1 from the end of SERVICE, data output still 00000000.
REQ-033 Length=0: Start then 16 valid bits -> no OutputValid, Done on the 16th consumed bit, Busy falls the next cycle.
REQ-034 Abort: Reset after the 3rd data bit of a Length=8 frame -> all outputs 0 next cycle, no Done; a new Start then decodes correctly.
REQ-035 Restart: Start re-asserted during SERVICE -> old frame discarded, no Done; new frame decoded from its first bit.
